sync_fifo_flags: RTL

Parametrised single-clock FIFO, successor to the team's dual-clock FIFO for same-domain buffering. Adds:
- an occupancy count;
- programmable almost-full and almost-empty thresholds;
- a synchronous flush;
- a registered read-valid strobe.

It keeps the same write/read enable interface and error-pulse interface, so producers and consumers port over unchanged.

---
 rtl/sync_fifo_flags.sv | 98 +++++++++
 1 files changed

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// synchronous flush, a registered read-valid strobe and write/read error pulses.
module sync_fifo_flags #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int PTR_WIDTH = 4,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 wr_en_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic                 rd_en_i,
    output logic [WIDTH-1:0]     rdata_o,
    output logic                 rvalid_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 almost_full_o,
    output logic                 almost_empty_o,
    output logic [PTR_WIDTH:0]   count_o,
    output logic                 wr_error_o,
    output logic                 rd_error_o
);

    localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] AF_C    = (PTR_WIDTH+1)'(AF_THRESH);
    localparam logic [PTR_WIDTH:0] AE_C    = (PTR_WIDTH+1)'(AE_THRESH);
    localparam logic [PTR_WIDTH:0] ONE_C   = (PTR_WIDTH+1)'(1);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_WIDTH:0] wr_ptr_q;
    logic [PTR_WIDTH:0] rd_ptr_q;
    logic [PTR_WIDTH:0] count_q;
    logic               wr_acc;
    logic               wr_rej;
    logic               rd_acc;
    logic               rd_rej;

    // Flags decode straight from the registered count, so they change with count_o.
    assign count_o        = count_q;
    assign full_o         = (count_q == DEPTH_C);
    assign empty_o        = (count_q == '0);
    assign almost_full_o  = (count_q >= AF_C);
    assign almost_empty_o = (count_q <= AE_C);

    // Handshake: a request is taken on the edge where its enable is high and the
    // pre-edge flag allows it (wr needs ~full_o, rd needs ~empty_o); a refused
    // request produces a one-cycle error pulse instead. Flush overrides both.
    assign wr_acc = ~flush_i & wr_en_i & ~full_o;
    assign wr_rej = ~flush_i & wr_en_i &  full_o;
    assign rd_acc = ~flush_i & rd_en_i & ~empty_o;
    assign rd_rej = ~flush_i & rd_en_i &  empty_o;

    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem[wr_ptr_q[PTR_WIDTH-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rdata_o    <= '0;
            rvalid_o   <= 1'b0;
            wr_error_o <= 1'b0;
            rd_error_o <= 1'b0;
        end else if (flush_i) begin
            // rdata_o deliberately keeps its last value across a flush.
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rvalid_o   <= 1'b0;
            wr_error_o <= 1'b0;
            rd_error_o <= 1'b0;
        end else begin
            wr_error_o <= wr_rej;
            rd_error_o <= rd_rej;
            rvalid_o   <= rd_acc;
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + ONE_C;
            end
            if (rd_acc) begin
                rd_ptr_q <= rd_ptr_q + ONE_C;
                rdata_o  <= mem[rd_ptr_q[PTR_WIDTH-1:0]];
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + ONE_C;
                2'b01:   count_q <= count_q - ONE_C;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
